// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: sequences the 8-bit ALU as a register-to-register datapath; ALU_EXEC_OVERLAP_EN accepts the next command in WB
module alu_exec_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_dst,
  input  logic [1:0] cmd_src_a,
  input  logic [1:0] cmd_src_b,
  input  logic [7:0] cmd_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       done
);
`ifdef ALU_EXEC_OVERLAP_EN
  localparam logic OVL = 1'b1;
`else
  localparam logic OVL = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t     state_q, state_d;
  logic       load_q, load_d, ready_q, ready_d, done_q, done_d, acc;
  logic [3:0] op_q, op_d;
  logic [1:0] dst_q, dst_d, src_a_q, src_a_d, src_b_q, src_b_d;
  logic [7:0] imm_q, imm_d, res_q, res_d;
  logic       cc_q, cc_d, cz_q, cz_d, cn_q, cn_d;
  logic       fc_q, fc_d, fz_q, fz_d, fn_q, fn_d;
  logic [7:0] rf_q [4];
  logic [7:0] rf_d [4];
  assign acc       = cmd_valid && ready_q;
  assign cmd_ready = ready_q;
  assign done      = done_q;
  assign alu_a     = rf_q[src_a_q];
  assign alu_b     = rf_q[src_b_q];
  assign alu_sel   = op_q;
  assign rd_data   = rf_q[rd_addr];
  assign flag_c    = fc_q;
  assign flag_z    = fz_q;
  assign flag_n    = fn_q;
  always_comb begin
    load_d  = acc ? cmd_load : load_q;
    op_d    = acc ? cmd_op : op_q;
    dst_d   = acc ? cmd_dst : dst_q;
    src_a_d = acc ? cmd_src_a : src_a_q;
    src_b_d = acc ? cmd_src_b : src_b_q;
    imm_d   = acc ? cmd_imm : imm_q;
    state_d = acc ? EXEC : state_q == EXEC ? WB : IDLE;
    res_d   = state_q == EXEC ? (load_q ? imm_q : alu_result) : res_q;
    cc_d    = state_q == EXEC ? alu_carry : cc_q;
    cz_d    = state_q == EXEC ? alu_zero : cz_q;
    cn_d    = state_q == EXEC ? alu_negative : cn_q;
    rf_d    = rf_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    fn_d    = fn_q;
    if (state_q == WB) begin
      rf_d[dst_q] = res_q;
      fz_d = load_q ? fz_q : cz_q;
      fn_d = load_q ? fn_q : cn_q;
      fc_d = (!load_q && op_q[3:2] == 2'b00) ? cc_q : fc_q;
    end
    done_d  = state_q == EXEC;
    ready_d = state_d == IDLE || (OVL && state_d == WB);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      op_q    <= '0;
      dst_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      cc_q    <= 1'b0;
      cz_q    <= 1'b0;
      cn_q    <= 1'b0;
      rf_q    <= '{default: 8'h00};
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      fn_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      cc_q    <= cc_d;
      cz_q    <= cz_d;
      cn_q    <= cn_d;
      rf_q    <= rf_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
      fn_q    <= fn_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed table, corner sequences and random commands against a register-file model
module tb_alu_exec_ctrl;
  logic       clk = 0, rst_n = 0, cmd_valid = 0, cmd_ready, cmd_load = 0;
  logic [3:0] cmd_op = 0, alu_sel;
  logic [1:0] cmd_dst = 0, cmd_src_a = 0, cmd_src_b = 0, rd_addr = 0;
  logic [7:0] cmd_imm = 0, alu_a, alu_b, alu_result, rd_data;
  logic       alu_carry, alu_zero, alu_negative, flag_c, flag_z, flag_n, done;
  int         pass = 0, total = 0;
  logic [7:0] rf_m [4];
  logic       fc_m, fz_m, fn_m;

  always #5 clk = ~clk;

  alu_exec_ctrl dut (.clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a),
    .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .rd_addr(rd_addr), .rd_data(rd_data), .flag_c(flag_c),
    .flag_z(flag_z), .flag_n(flag_n), .done(done));

  // Stand-in for ALU_1: returns {carry, zero, negative, result}
  function automatic logic [10:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    case (s)
      4'd0:    w = {1'b0, a} + {1'b0, b};
      4'd1:    w = {1'b0, a} - {1'b0, b};
      4'd2:    w = {1'b0, a} + 9'd1;
      4'd3:    w = {1'b0, a} - 9'd1;
      4'd4:    w = {1'b0, a & b};
      4'd5:    w = {1'b0, a | b};
      4'd6:    w = {1'b1, a ^ b};
      4'd7:    w = {1'b0, ~a};
      4'd8:    w = {a, 1'b0};
      4'd9:    w = {a[0], 1'b0, a[7:1]};
      default: w = {b[0], a};
    endcase
    return {w[8], w[7:0] == 8'h00, w[7], w[7:0]};
  endfunction

  assign {alu_carry, alu_zero, alu_negative, alu_result} = alu_f(alu_sel, alu_a, alu_b);

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
    {fc_m, fz_m, fn_m} = 3'b000;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1 check({tag, "_rf"}, rd_data, rf_m[i]);
    end
    check({tag, "_flags"}, {5'd0, flag_c, flag_z, flag_n}, {5'd0, fc_m, fz_m, fn_m});
  endtask

  task automatic issue(input logic ld, input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                       input logic [1:0] b, input logic [7:0] imm);
    int k = 0;
    logic r = 0;
    logic [10:0] o;
    {cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm} = {ld, op, d, a, b, imm};
    cmd_valid = 1;
    while (!r && k < 10) begin
      r = cmd_ready;
      @(posedge clk);
      k++;
      #1;
    end
    cmd_valid = 0;
    {cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm} = 19'($urandom);
    if (!r) begin
      check("handshake_timeout", 8'd0, 8'd1);
      return;
    end
    check("done_exec", {7'd0, done}, 8'd0);
    if (!ld) begin
      check("alu_a", alu_a, rf_m[a]);
      check("alu_b", alu_b, rf_m[b]);
      check("alu_sel", {4'd0, alu_sel}, {4'd0, op});
      o = alu_f(op, rf_m[a], rf_m[b]);
      rf_m[d] = o[7:0];
      fz_m = o[9];
      fn_m = o[8];
      if (op[3:2] == 2'b00) fc_m = o[10];
    end else rf_m[d] = imm;
    @(posedge clk); #1;
    check("done_wb", {7'd0, done}, 8'd1);
    @(posedge clk); #1;
    check("done_after", {7'd0, done}, 8'd0);
    rd_addr = d;
    #1 check("rd_dst", rd_data, rf_m[d]);
    check("flags", {5'd0, flag_c, flag_z, flag_n}, {5'd0, fc_m, fz_m, fn_m});
  endtask

  typedef struct {
    logic ld; logic [3:0] op; logic [1:0] d, a, b; logic [7:0] imm;
    logic [7:0] ev; logic [2:0] ef;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int hs [2];
    int n;
    logic r;
    tbl[0] = '{1, 4'd0, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 3'b000};
    tbl[1] = '{1, 4'd0, 2'd1, 2'd0, 2'd0, 8'h20, 8'h20, 3'b000};
    tbl[2] = '{0, 4'd0, 2'd2, 2'd0, 2'd1, 8'h00, 8'h10, 3'b100};
    tbl[3] = '{0, 4'd4, 2'd3, 2'd0, 2'd1, 8'h00, 8'h20, 3'b100};
    tbl[4] = '{0, 4'd1, 2'd2, 2'd1, 2'd1, 8'h00, 8'h00, 3'b010};
    tbl[5] = '{0, 4'd7, 2'd3, 2'd1, 2'd0, 8'h00, 8'hDF, 3'b001};
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("rst_ready", {7'd0, cmd_ready}, 8'd1);
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_alu", {alu_sel, 4'd0}, 8'd0);
    check("rst_alu_ab", alu_a | alu_b, 8'd0);
    check_state("rst");

    foreach (tbl[i]) begin
      issue(tbl[i].ld, tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].imm);
      rd_addr = tbl[i].d;
      #1 check("tbl_val", rd_data, tbl[i].ev);
      check("tbl_flags", {5'd0, flag_c, flag_z, flag_n}, {5'd0, tbl[i].ef});
    end

    // Reset during EXEC must abandon the ADD
    {cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b} = {1'b0, 4'd0, 2'd2, 2'd0, 2'd1};
    cmd_valid = 1;
    r = 0;
    for (int i = 0; i < 10 && !r; i++) begin
      r = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    rst_n = 0;
    check("midrst_done0", {7'd0, done}, 8'd0);
    @(posedge clk); #1;
    check("midrst_done1", {7'd0, done}, 8'd0);
    rst_n = 1;
    @(posedge clk); #1;
    check("midrst_done2", {7'd0, done}, 8'd0);
    model_reset();
    check_state("midrst");

    // Back-to-back INC r0 with cmd_valid held high
    issue(1, 4'd0, 2'd0, 2'd0, 2'd0, 8'h05);
    {cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b} = {1'b0, 4'd2, 2'd0, 2'd0, 2'd0};
    cmd_valid = 1;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      r = cmd_ready;
      @(posedge clk);
      if (r) hs[n++] = i;
      #1;
    end
    cmd_valid = 0;
    check("b2b_count", 8'(n), 8'd2);
`ifdef ALU_EXEC_OVERLAP_EN
    check("b2b_gap", 8'(hs[1] - hs[0]), 8'd2);
`else
    check("b2b_gap", 8'(hs[1] - hs[0]), 8'd3);
`endif
    repeat (3) @(posedge clk);
    #1 rd_addr = 2'd0;
    #1 check("b2b_r0", rd_data, 8'h07);
    rf_m[0] = 8'h07;
    fz_m = 0;
    fn_m = 0;
    fc_m = 0;
    check_state("b2b");

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue($urandom_range(0, 3) == 0, 4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    end
    check_state("final");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execution controller that sits directly upstream of the 8-bit ALU (`ALU_1`) and feeds it. The controller accepts commands over a valid/ready handshake and holds a 4-entry × 8-bit register file. For each command it drives the ALU operand and select inputs from that register file. It then captures the ALU result and flags, and writes the result back to the register file and a flag register. It turns the purely combinational ALU into a sequenced, register-to-register datapath.

## Interface
- No parameters; widths are fixed to match the 8-bit ALU.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command this cycle.
- `cmd_load`  in  1  1 = load `cmd_imm` into `cmd_dst`; 0 = ALU operation.
- `cmd_op`  in  4  ALU select code (0000–1111); ignored when `cmd_load` = 1.
- `cmd_dst`  in  2  destination register index.
- `cmd_src_a`, `cmd_src_b`  in  2 each  source register indices.
- `cmd_imm`  in  8  immediate value for load commands.
- `alu_a`, `alu_b`  out  8 each  ALU operands.
- `alu_sel`  out  4  ALU select.
- `alu_result`  in  8  ALU result.
- `alu_carry`, `alu_zero`, `alu_negative`  in  1 each  ALU flags.
- `rd_addr`  in  2  debug read index.
- `rd_data`  out  8  combinational read: `rf[rd_addr]`.
- `flag_c`, `flag_z`, `flag_n`  out  1 each  architectural flag register.
- `done`  out  1  one-cycle pulse when a command retires.

## Operation
- FSM states are IDLE, EXEC and WB. Reset state is IDLE.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`, latch `cmd_load`, `cmd_op`, `cmd_dst`, `cmd_src_a`, `cmd_src_b` and `cmd_imm`, then go to EXEC.
  - With `cmd_valid` = 0, stay in IDLE.
- **EXEC**
  - `cmd_ready` = 0.
  - `alu_a` = `rf[src_a_q]`, `alu_b` = `rf[src_b_q]`, `alu_sel` = `op_q`.
  - At the end of the cycle, capture into `res_q`:
    - ALU op: `alu_result`, `alu_carry`, `alu_zero` and `alu_negative`.
    - Load: `imm_q`.
  - Then go to WB.
- **WB**
  - Write `rf[dst_q] <= res_q` (both loads and ALU ops).
  - Flag updates for ALU ops only; loads leave all flags unchanged:
    - `flag_z` and `flag_n` take the captured values.
    - `flag_c` takes the captured carry only when `op_q[3:2]` = 00 (ADD/SUB/INC/DEC); otherwise it holds its value.
  - `done` = 1; then go to IDLE.
- Outside EXEC, `alu_a`, `alu_b` and `alu_sel` still reflect the latched indices and op. Their values are don't-care and are not sampled.
- A destination equal to a source is legal. Sources are read in EXEC; the write occurs at the WB edge.
- `rd_data` shows the post-write value starting the cycle after WB.

## Timing
- Reset values (`rst_n` = 0 at an edge):
  - state = IDLE, `cmd_ready` = 1, `done` = 0.
  - `rf[0..3]` = 0x00 and all flags = 0.
  - Latched command fields = 0, so `alu_a` = `alu_b` = 0x00 and `alu_sel` = 0000.
- Reset asserted in EXEC or WB abandons the command. No register-file or flag write occurs, and `done` stays 0.
- Latency from the handshake edge:
  - EXEC follows in cycle +1.
  - WB and the `done` pulse follow in cycle +2.
  - The written value is visible on `rd_data` in cycle +3.
- Throughput is one command per 3 cycles in the default build.
- `cmd_*` inputs are sampled only on the handshake edge. They may change freely otherwise.
- Arithmetic is owned by the ALU; the controller does no width extension or modification of results.

## Configuration
- Macro: `ALU_EXEC_OVERLAP_EN`.
- **Defined**
  - `cmd_ready` = 1 in WB as well as in IDLE.
  - A command accepted in WB goes directly to EXEC (no IDLE cycle), giving a throughput of one command per 2 cycles.
  - The new command reads its sources in the following EXEC, after the WB write has committed. No forwarding logic is needed, and a read-after-write on the same register returns the new value.
- **Undefined**
  - `cmd_ready` = 0 in WB; behaviour is as described above.

## Test plan
- Reset: drive `rst_n` low for 2 cycles.
  - Expect `cmd_ready` = 1, all `rf` entries = 0x00 via `rd_data`, and flags = 000.
- Load then add: load r0 = 0xF0 and r1 = 0x20, then ADD r2 = r0 + r1.
  - Expect `rf[2]` = 0x10, `flag_c` = 1, `flag_z` = 0, `flag_n` = 0.
  - Expect `done` to pulse 2 cycles after each handshake.
- Carry hold: after the ADD above, issue AND r3 = r0 & r1 (0xF0 & 0x20 = 0x20).
  - Expect `rf[3]` = 0x20, `flag_c` to stay 1, and `flag_z` = 0.
- Zero/negative flags:
  - SUB r2 = r1 − r1 → 0x00, `flag_z` = 1, `flag_n` = 0.
  - NOT r3 = ~r1 → 0xDF, `flag_n` = 1, `flag_z` = 0.
- Reset mid-operation: accept ADD r2 = r0 + r1, then assert `rst_n` = 0 during EXEC.
  - Expect no `done` pulse and `rf[2]` = 0x00.
- Back-to-back with `ALU_EXEC_OVERLAP_EN` defined: INC r0 (0x05 → 0x06), then INC r0 again, holding `cmd_valid` high.
  - Expect the handshakes 2 cycles apart and the final `rf[0]` = 0x07.
  - Without the macro, expect the handshakes 3 cycles apart and the same final value.
